// File: rtl/ddr3_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_phy_pkg
// Brief    : Shared types and constants for the DDR3 CA lane driver slice:
//            delay sequencer state encoding, tap width, default timing
//            constants and a saturating tap-step helper.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_phy_pkg;

    // Width of the tracked delay-line tap estimate
    localparam int TAP_W = 8;

    // Default settle wait after each delay-line move
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    // Default tap value matching the IOD's static TX delay
    localparam int DEFAULT_INIT_TAP = 1;

    // Delay sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } dly_state_t;

    // One tap step in the requested direction, clamped to the tap range
    function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap,
                                                  input logic             inc);
        if (inc) begin
            return (tap == '1) ? tap : tap + 1'b1;
        end
        return (tap == '0) ? tap : tap - 1'b1;
    endfunction

endpackage : ddr3_phy_pkg
`default_nettype wire

// File: rtl/ddr3_dly_step_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_dly_step_fsm
// Brief    : Request/acknowledge sequencer that steps the IOD output delay
//            line N taps (or reloads it), waiting a settle period after each
//            move and sampling out-of-range before committing the step.
//            Also keeps the tap estimate and the sticky out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_dly_step_fsm
    import ddr3_phy_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int INIT_TAP      = DEFAULT_INIT_TAP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic             i_dir,
    input  logic [TAP_W-1:0] i_steps,
    input  logic             i_load_req,
    input  logic             i_out_of_range,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_oor,
    output logic [TAP_W-1:0] o_tap,
    output logic             o_move,
    output logic             o_direction,
    output logic             o_load
);

    localparam logic [3:0]       C_SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [TAP_W-1:0] C_INIT_TAP    = TAP_W'(INIT_TAP);

    dly_state_t       r_state,      w_state_nxt;
    logic [TAP_W-1:0] r_remaining,  w_remaining_nxt;
    logic [3:0]       r_settle_cnt, w_settle_cnt_nxt;
    logic [TAP_W-1:0] r_tap,        w_tap_nxt;
    logic             r_oor,        w_oor_nxt;
    logic             r_dir,        w_dir_nxt;

    // State and sequencer bookkeeping registers; reset aborts any sequence
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_settle_cnt <= '0;
            r_tap        <= C_INIT_TAP;
            r_oor        <= 1'b0;
            r_dir        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_tap        <= w_tap_nxt;
            r_oor        <= w_oor_nxt;
            r_dir        <= w_dir_nxt;
        end
    end

    // Next-state logic: load wins over move in IDLE, requests ignored elsewhere
    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_settle_cnt_nxt = r_settle_cnt;
        w_tap_nxt        = r_tap;
        w_oor_nxt        = r_oor;
        w_dir_nxt        = r_dir;

        case (r_state)
            ST_IDLE: begin
                if (i_load_req) begin
                    w_state_nxt = ST_LOAD;
                end else if (i_req) begin
                    w_dir_nxt       = i_dir;
                    w_remaining_nxt = i_steps;
                    w_state_nxt     = (i_steps == '0) ? ST_DONE : ST_MOVE;
                end
            end

            ST_LOAD: begin
                w_tap_nxt   = C_INIT_TAP;
                w_oor_nxt   = 1'b0;
                w_state_nxt = ST_DONE;
            end

            ST_MOVE: begin
                w_settle_cnt_nxt = C_SETTLE_LOAD;
                w_state_nxt      = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (r_settle_cnt == 4'd1) begin
                    // Delay line has settled: commit the step or abort on range error
                    w_settle_cnt_nxt = '0;
                    if (i_out_of_range) begin
                        w_oor_nxt       = 1'b1;
                        w_remaining_nxt = '0;
                        w_state_nxt     = ST_DONE;
                    end else begin
                        w_tap_nxt       = tap_step(r_tap, r_dir);
                        w_remaining_nxt = r_remaining - 1'b1;
                        w_state_nxt     = (r_remaining == TAP_W'(1)) ? ST_DONE : ST_MOVE;
                    end
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_move      = (r_state == ST_MOVE);
    assign o_load      = (r_state == ST_LOAD);
    assign o_direction = r_dir;
    assign o_oor       = r_oor;
    assign o_tap       = r_tap;

endmodule : ddr3_dly_step_fsm
`default_nettype wire

// File: rtl/ddr3_ca_lane_driver.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ca_lane_driver
// Brief    : Fabric-side driver for one DDR3 address/command pin. Registers
//            the four DFI phase bits and the replicated drive enable into the
//            IOD 4:1 TX/OE gearing, and hosts the delay-line step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ca_lane_driver
    import ddr3_phy_pkg::*;
#(
    parameter int TX_LATENCY    = 1,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int INIT_TAP      = DEFAULT_INIT_TAP
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic [3:0]       DFI_ADDR_P,
    input  logic             DFI_OE,
    output logic [3:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    input  logic             DLY_REQ,
    input  logic             DLY_DIR,
    input  logic [TAP_W-1:0] DLY_STEPS,
    input  logic             DLY_LOAD_REQ,
    output logic             DLY_BUSY,
    output logic             DLY_DONE,
    output logic             DLY_OOR,
    output logic [TAP_W-1:0] DLY_TAP,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    // Stage 0 captures the DFI inputs; the last stage feeds the IOD directly
    logic [TX_LATENCY-1:0][3:0] r_tx_pipe;
    logic [TX_LATENCY-1:0][3:0] r_oe_pipe;

    // TX/OE shift pipeline, independent of the delay sequencer
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_tx_pipe <= '0;
            r_oe_pipe <= '0;
        end else begin
            r_tx_pipe[0] <= DFI_ADDR_P;
            r_oe_pipe[0] <= {4{DFI_OE}};
            for (int i = 1; i < TX_LATENCY; i++) begin
                r_tx_pipe[i] <= r_tx_pipe[i-1];
                r_oe_pipe[i] <= r_oe_pipe[i-1];
            end
        end
    end

    assign TX_DATA_0 = r_tx_pipe[TX_LATENCY-1];
    assign OE_DATA_0 = r_oe_pipe[TX_LATENCY-1];

    ddr3_dly_step_fsm #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .INIT_TAP      (INIT_TAP)
    ) u_dly_step_fsm (
        .i_clk          (FAB_CLK),
        .i_rst_n        (ARST_N),
        .i_req          (DLY_REQ),
        .i_dir          (DLY_DIR),
        .i_steps        (DLY_STEPS),
        .i_load_req     (DLY_LOAD_REQ),
        .i_out_of_range (DELAY_LINE_OUT_OF_RANGE_0),
        .o_busy         (DLY_BUSY),
        .o_done         (DLY_DONE),
        .o_oor          (DLY_OOR),
        .o_tap          (DLY_TAP),
        .o_move         (DELAY_LINE_MOVE_0),
        .o_direction    (DELAY_LINE_DIRECTION_0),
        .o_load         (DELAY_LINE_LOAD_0)
    );

endmodule : ddr3_ca_lane_driver
`default_nettype wire

// File: tb/tb_ddr3_ca_lane_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_ca_lane_driver
// Brief    : Self-checking bench for the DDR3 CA lane driver: TX/OE latency,
//            delay move / abort / load sequences, request filtering and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_ca_lane_driver;

    localparam int L    = 2;
    localparam int S    = 4;
    localparam int INIT = 1;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic [3:0] DFI_ADDR_P;
    logic       DFI_OE;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       DLY_REQ;
    logic       DLY_DIR;
    logic [7:0] DLY_STEPS;
    logic       DLY_LOAD_REQ;
    logic       DLY_BUSY;
    logic       DLY_DONE;
    logic       DLY_OOR;
    logic [7:0] DLY_TAP;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the delay line should look like after each sequence
    int   m_tap = INIT;
    logic m_oor = 1'b0;
    logic m_dir = 1'b0;

    // Per-cycle observations {busy, move, done, load, direction} of the last sequence
    logic [4:0] obs_q[$];
    logic [7:0] obs_tap;
    logic       obs_oor;

    ddr3_ca_lane_driver #(
        .TX_LATENCY    (L),
        .SETTLE_CYCLES (S),
        .INIT_TAP      (INIT)
    ) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .DFI_ADDR_P                (DFI_ADDR_P),
        .DFI_OE                    (DFI_OE),
        .TX_DATA_0                 (TX_DATA_0),
        .OE_DATA_0                 (OE_DATA_0),
        .DLY_REQ                   (DLY_REQ),
        .DLY_DIR                   (DLY_DIR),
        .DLY_STEPS                 (DLY_STEPS),
        .DLY_LOAD_REQ              (DLY_LOAD_REQ),
        .DLY_BUSY                  (DLY_BUSY),
        .DLY_DONE                  (DLY_DONE),
        .DLY_OOR                   (DLY_OOR),
        .DLY_TAP                   (DLY_TAP),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Cycle (counted from the request edge) in which DONE is expected
    function automatic int exp_done(input bit is_load, input int n, input int oor_step);
        if (is_load) return 2;
        if (oor_step >= 1 && oor_step <= n) return 1 + oor_step * (S + 1);
        return 1 + n * (S + 1);
    endfunction

    // Expected {busy, move, done, load, direction} in cycle c of a sequence
    function automatic logic [4:0] exp_ctrl(input bit is_load, input int n,
                                            input int oor_step, input int c);
        int   d;
        logic busy, mv, dn, ld;
        d    = exp_done(is_load, n, oor_step);
        busy = (c <= d);
        mv   = !is_load && (c < d) && (((c - 1) % (S + 1)) == 0);
        dn   = (c == d);
        ld   = is_load && (c == 1);
        return {busy, mv, dn, ld, m_dir};
    endfunction

    // Model update for one accepted sequence
    task automatic mdl_apply(input bit is_load, input bit dir, input int n, input int oor_step);
        bit hit;
        int succ;
        if (is_load) begin
            m_tap = INIT;
            m_oor = 1'b0;
        end else begin
            hit  = (oor_step >= 1 && oor_step <= n);
            succ = hit ? oor_step - 1 : n;
            if (dir) m_tap = (m_tap + succ > 255) ? 255 : m_tap + succ;
            else     m_tap = (m_tap - succ < 0)   ? 0   : m_tap - succ;
            if (hit) m_oor = 1'b1;
            m_dir = dir;
        end
    endtask

    // Issue one request from IDLE (called at a falling edge) and record the
    // response for every cycle through one cycle past the expected DONE
    task automatic run_seq(input bit is_load, input bit also_req, input bit dir,
                           input int n, input int oor_step, input bit noise);
        int d;
        d = exp_done(is_load, n, oor_step);
        obs_q.delete();
        DLY_LOAD_REQ = is_load;
        DLY_REQ      = !is_load || also_req;
        DLY_DIR      = dir;
        DLY_STEPS    = 8'(n);
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge FAB_CLK);
            obs_q.push_back({DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0,
                             DELAY_LINE_DIRECTION_0});
            if (c == d) begin
                obs_tap = DLY_TAP;
                obs_oor = DLY_OOR;
            end
            if (noise && c < d) begin
                DLY_REQ      = 1'($urandom_range(0, 1));
                DLY_LOAD_REQ = 1'($urandom_range(0, 1));
                DLY_DIR      = 1'($urandom_range(0, 1));
                DLY_STEPS    = 8'($urandom_range(0, 255));
            end else begin
                DLY_REQ      = 1'b0;
                DLY_LOAD_REQ = 1'b0;
            end
            DELAY_LINE_OUT_OF_RANGE_0 = !is_load && (c < d) && (((c - 1) / (S + 1) + 1) == oor_step);
        end
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    endtask

    task automatic test_reset();
        ARST_N       = 1'b0;
        DFI_ADDR_P   = 4'hF;
        DFI_OE       = 1'b1;
        DLY_REQ      = 1'b1;
        DLY_LOAD_REQ = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        n_checks++;
        if (TX_DATA_0 !== 4'h0) begin
            n_fail++; $display("FAIL reset_tx: got %h required 0", TX_DATA_0);
        end
        n_checks++;
        if (OE_DATA_0 !== 4'h0) begin
            n_fail++; $display("FAIL reset_oe: got %h required 0", OE_DATA_0);
        end
        n_checks++;
        if ({DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0, DLY_OOR} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0, DLY_OOR});
        end
        n_checks++;
        if (DLY_TAP !== 8'(INIT)) begin
            n_fail++; $display("FAIL reset_tap: got %0d required %0d", DLY_TAP, INIT);
        end
        DFI_ADDR_P = 4'h0;
        DFI_OE     = 1'b0;
        DLY_REQ    = 1'b0;
        ARST_N     = 1'b1;
        @(negedge FAB_CLK);
        n_checks++;
        if (DLY_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: busy got %b required 0", DLY_BUSY);
        end
    endtask

    task automatic test_datapath();
        logic [4:0] hist[$];
        logic [4:0] v;
        logic [4:0] e;
        for (int i = 0; i < L; i++) hist.push_back(5'd0);
        for (int k = 0; k < 36; k++) begin
            @(negedge FAB_CLK);
            e = hist[hist.size() - L];
            n_checks++;
            if (TX_DATA_0 !== e[3:0]) begin
                n_fail++; $display("FAIL datapath_tx step %0d: got %h required %h", k, TX_DATA_0, e[3:0]);
            end
            n_checks++;
            if (OE_DATA_0 !== {4{e[4]}}) begin
                n_fail++; $display("FAIL datapath_oe step %0d: got %h required %h", k, OE_DATA_0, {4{e[4]}});
            end
            if (k < 2)      v = {1'b1, 4'hA};
            else if (k < 4) v = {1'b0, 4'hA};
            else            v = 5'($urandom);
            DFI_ADDR_P = v[3:0];
            DFI_OE     = v[4];
            hist.push_back(v);
        end
        DFI_ADDR_P = 4'h0;
        DFI_OE     = 1'b0;
    endtask

    task automatic test_move();
        run_seq(1'b0, 1'b0, 1'b1, 3, 0, 1'b0);
        mdl_apply(1'b0, 1'b1, 3, 0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_ctrl(1'b0, 3, 0, i + 1)) begin
                n_fail++; $display("FAIL move_ctrl cycle %0d: got %b required %b", i + 1, obs_q[i], exp_ctrl(1'b0, 3, 0, i + 1));
            end
        end
        n_checks++;
        if (obs_tap !== 8'd4) begin
            n_fail++; $display("FAIL move_tap: got %0d required 4", obs_tap);
        end
        n_checks++;
        if (obs_oor !== 1'b0) begin
            n_fail++; $display("FAIL move_oor: got %b required 0", obs_oor);
        end
    endtask

    task automatic test_oor_abort();
        run_seq(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        mdl_apply(1'b1, 1'b0, 0, 0);
        n_checks++;
        if (obs_tap !== 8'(m_tap)) begin
            n_fail++; $display("FAIL oor_preload_tap: got %0d required %0d", obs_tap, m_tap);
        end
        run_seq(1'b0, 1'b0, 1'b0, 5, 2, 1'b0);
        mdl_apply(1'b0, 1'b0, 5, 2);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_ctrl(1'b0, 5, 2, i + 1)) begin
                n_fail++; $display("FAIL oor_ctrl cycle %0d: got %b required %b", i + 1, obs_q[i], exp_ctrl(1'b0, 5, 2, i + 1));
            end
        end
        n_checks++;
        if (obs_q.size() != 12 || obs_q[10][2] !== 1'b1) begin
            n_fail++; $display("FAIL oor_done_cycle: got size %0d required DONE in cycle 11", obs_q.size());
        end
        n_checks++;
        if (obs_tap !== 8'd0) begin
            n_fail++; $display("FAIL oor_tap: got %0d required 0", obs_tap);
        end
        n_checks++;
        if (obs_oor !== 1'b1) begin
            n_fail++; $display("FAIL oor_flag: got %b required 1", obs_oor);
        end
    endtask

    task automatic test_load_priority();
        run_seq(1'b1, 1'b1, ~m_dir, 3, 0, 1'b0);
        mdl_apply(1'b1, 1'b0, 0, 0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_ctrl(1'b1, 0, 0, i + 1)) begin
                n_fail++; $display("FAIL load_ctrl cycle %0d: got %b required %b", i + 1, obs_q[i], exp_ctrl(1'b1, 0, 0, i + 1));
            end
        end
        n_checks++;
        if (obs_tap !== 8'(INIT)) begin
            n_fail++; $display("FAIL load_tap: got %0d required %0d", obs_tap, INIT);
        end
        n_checks++;
        if (obs_oor !== 1'b0) begin
            n_fail++; $display("FAIL load_oor_clear: got %b required 0", obs_oor);
        end
    endtask

    task automatic test_zero_steps();
        run_seq(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        mdl_apply(1'b0, 1'b1, 0, 0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_ctrl(1'b0, 0, 0, i + 1)) begin
                n_fail++; $display("FAIL zero_ctrl cycle %0d: got %b required %b", i + 1, obs_q[i], exp_ctrl(1'b0, 0, 0, i + 1));
            end
        end
        n_checks++;
        if (obs_tap !== 8'(m_tap)) begin
            n_fail++; $display("FAIL zero_tap: got %0d required %0d", obs_tap, m_tap);
        end
    endtask

    task automatic test_busy_ignore();
        // Two decrements from tap 1 also exercise the clamp at zero
        run_seq(1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
        mdl_apply(1'b0, 1'b0, 2, 0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_ctrl(1'b0, 2, 0, i + 1)) begin
                n_fail++; $display("FAIL busy_ignore_ctrl cycle %0d: got %b required %b", i + 1, obs_q[i], exp_ctrl(1'b0, 2, 0, i + 1));
            end
        end
        n_checks++;
        if (obs_tap !== 8'(m_tap)) begin
            n_fail++; $display("FAIL busy_ignore_tap: got %0d required %0d", obs_tap, m_tap);
        end
    endtask

    task automatic test_saturation_high();
        run_seq(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        mdl_apply(1'b1, 1'b0, 0, 0);
        run_seq(1'b0, 1'b0, 1'b1, 255, 0, 1'b0);
        mdl_apply(1'b0, 1'b1, 255, 0);
        n_checks++;
        if (obs_q.size() != 1 + 255 * (S + 1) + 1 || obs_q[255 * (S + 1)][2] !== 1'b1) begin
            n_fail++; $display("FAIL sat_done_cycle: got size %0d required DONE in cycle %0d", obs_q.size(), 1 + 255 * (S + 1));
        end
        n_checks++;
        if (obs_tap !== 8'd255) begin
            n_fail++; $display("FAIL sat_tap: got %0d required 255", obs_tap);
        end
    endtask

    task automatic test_random();
        bit is_load, dir, noise;
        int n, oor_step;
        for (int t = 0; t < 30; t++) begin
            is_load  = ($urandom_range(0, 5) == 0);
            dir      = 1'($urandom_range(0, 1));
            n        = $urandom_range(0, 6);
            oor_step = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
            noise    = 1'($urandom_range(0, 1));
            run_seq(is_load, 1'($urandom_range(0, 1)), dir, n, oor_step, noise);
            mdl_apply(is_load, dir, n, oor_step);
            foreach (obs_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_ctrl(is_load, n, oor_step, i + 1)) begin
                    n_fail++;
                    $display("FAIL random_ctrl trial %0d cycle %0d: got %b required %b", t, i + 1, obs_q[i], exp_ctrl(is_load, n, oor_step, i + 1));
                end
            end
            n_checks++;
            if (obs_tap !== 8'(m_tap)) begin
                n_fail++; $display("FAIL random_tap trial %0d: got %0d required %0d", t, obs_tap, m_tap);
            end
            n_checks++;
            if (obs_oor !== m_oor) begin
                n_fail++; $display("FAIL random_oor trial %0d: got %b required %b", t, obs_oor, m_oor);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        // Leave the tracker away from its reset values first
        run_seq(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        mdl_apply(1'b1, 1'b0, 0, 0);
        run_seq(1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
        mdl_apply(1'b0, 1'b1, 3, 3);
        n_checks++;
        if (obs_tap !== 8'(m_tap) || obs_oor !== m_oor) begin
            n_fail++; $display("FAIL pre_reset_state: got tap %0d oor %b required tap %0d oor %b", obs_tap, obs_oor, m_tap, m_oor);
        end
        DFI_ADDR_P = 4'h5;
        DFI_OE     = 1'b1;
        DLY_REQ    = 1'b1;
        DLY_DIR    = 1'b1;
        DLY_STEPS  = 8'd3;
        @(negedge FAB_CLK);
        DLY_REQ = 1'b0;
        repeat (2) @(negedge FAB_CLK);
        n_checks++;
        if (DLY_BUSY !== 1'b1 || DELAY_LINE_MOVE_0 !== 1'b0) begin
            n_fail++; $display("FAIL mid_settle_busy: got busy %b move %b required 1 0", DLY_BUSY, DELAY_LINE_MOVE_0);
        end
        ARST_N = 1'b0;
        #1;
        m_tap = INIT;
        m_oor = 1'b0;
        m_dir = 1'b0;
        n_checks++;
        if ({TX_DATA_0, OE_DATA_0} !== 8'h00) begin
            n_fail++; $display("FAIL arst_data: got %h required 00", {TX_DATA_0, OE_DATA_0});
        end
        n_checks++;
        if ({DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0, DLY_OOR} !== 6'b0) begin
            n_fail++;
            $display("FAIL arst_ctrl: got %b required 000000",
                     {DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0, DLY_OOR});
        end
        n_checks++;
        if (DLY_TAP !== 8'(m_tap)) begin
            n_fail++; $display("FAIL arst_tap: got %0d required %0d", DLY_TAP, m_tap);
        end
        @(negedge FAB_CLK);
        DFI_ADDR_P = 4'h0;
        DFI_OE     = 1'b0;
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge FAB_CLK);
            n_checks++;
            if ({DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0} !== 4'b0) begin
                n_fail++;
                $display("FAIL post_arst_quiet cycle %0d: got %b required 0000", c,
                         {DLY_BUSY, DELAY_LINE_MOVE_0, DLY_DONE, DELAY_LINE_LOAD_0});
            end
        end
        n_checks++;
        if (DLY_TAP !== 8'(m_tap) || DLY_OOR !== m_oor) begin
            n_fail++; $display("FAIL post_arst_state: got tap %0d oor %b required tap %0d oor %b", DLY_TAP, DLY_OOR, m_tap, m_oor);
        end
    endtask

    initial begin
        ARST_N                    = 1'b0;
        DFI_ADDR_P                = 4'h0;
        DFI_OE                    = 1'b0;
        DLY_REQ                   = 1'b0;
        DLY_DIR                   = 1'b0;
        DLY_STEPS                 = 8'd0;
        DLY_LOAD_REQ              = 1'b0;
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

        test_reset();
        test_datapath();
        test_move();
        test_oor_abort();
        test_load_priority();
        test_zero_steps();
        test_busy_ignore();
        test_saturation_high();
        test_random();
        test_reset_mid_settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ddr3_ca_lane_driver
`default_nettype wire

// File: doc/ddr3_ca_lane_driver.md
# ddr3_ca_lane_driver

Fabric-side driver for one DDR3 address/command lane, sitting directly upstream of the per-pin IOD wrapper. It registers four DFI phase bits per FAB_CLK into the IOD's 4:1 TX gearing, and it generates the matching output-enable nibble. It also runs a request/acknowledge sequencer that steps the IOD's dynamic output delay line by N taps, checking delay-line out-of-range after each step. One instance serves each CA pin; training logic issues the delay requests.

## Interface
- TX_LATENCY, 1: register stages on the TX/OE data path, legal 1..3.
- SETTLE_CYCLES, 4: wait cycles after each delay MOVE before out-of-range is sampled, legal 1..15.
- INIT_TAP, 1: tap value loaded into the tap tracker on LOAD; matches the IOD's static TX delay.
- FAB_CLK  in  1  sole clock; the IOD TX_CLK domain.
- ARST_N  in  1  asynchronous, active-low reset.
- DFI_ADDR_P  in  4  phase bits; bit0 goes on the wire first.
- DFI_OE  in  1  lane drive enable for this FAB_CLK cycle.
- TX_DATA_0  out  4  to IOD TX_DATA nibble.
- OE_DATA_0  out  4  to IOD OE_DATA nibble.
- DLY_REQ  in  1  start an N-step move (sampled only in IDLE).
- DLY_DIR  in  1  1 = increment delay, 0 = decrement.
- DLY_STEPS  in  8  number of steps N.
- DLY_LOAD_REQ  in  1  reload the delay line to its static value.
- DLY_BUSY  out  1  sequencer not in IDLE.
- DLY_DONE  out  1  one-cycle completion pulse.
- DLY_OOR  out  1  sticky out-of-range flag.
- DLY_TAP  out  8  tracked tap estimate.
- DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0  out  1 each  to the IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from the IOD.

## Operation
- Data path:
  - TX_DATA_0 = DFI_ADDR_P delayed by TX_LATENCY registers.
  - OE_DATA_0 = {4{DFI_OE}}, with identical latency.
  - No dependency on sequencer state.
- Sequencer states: IDLE, LOAD, MOVE, SETTLE, DONE.
- IDLE:
  - DLY_LOAD_REQ=1 -> LOAD. This has priority over a simultaneous DLY_REQ; that DLY_REQ is dropped, not queued.
  - Otherwise DLY_REQ=1 -> latch DLY_DIR into DELAY_LINE_DIRECTION_0 and DLY_STEPS into the remaining counter. Go to MOVE if N>0, or directly to DONE if N=0 (no MOVE pulse).
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle; DLY_TAP<=INIT_TAP; DLY_OOR<=0; -> DONE.
- MOVE: DELAY_LINE_MOVE_0=1 for one cycle; -> SETTLE with the settle counter = SETTLE_CYCLES.
- SETTLE: counts down. On the last settle cycle, DELAY_LINE_OUT_OF_RANGE_0 is sampled:
  - If 1: DLY_OOR<=1, DLY_TAP is unchanged, remaining steps are abandoned, -> DONE.
  - If 0: DLY_TAP +/-1 (saturating at 0/255) and remaining -1. If remaining reaches 0 -> DONE, else -> MOVE.
- DONE: DLY_DONE=1 for one cycle; -> IDLE.
- Requests seen while DLY_BUSY=1 are ignored.
- DELAY_LINE_DIRECTION_0 holds its latched value until the next accepted DLY_REQ.
- DLY_OOR clears only on LOAD or reset.

## Timing
- Reset values:
  - All outputs 0 except DLY_TAP=INIT_TAP.
  - State IDLE; all TX/OE pipeline registers 0.
  - Reset asserted mid-sequence aborts immediately, with no DONE pulse.
- Data latency: a DFI input sampled at edge k appears on TX_DATA_0/OE_DATA_0 after edge k+TX_LATENCY-1 (TX_LATENCY=1 means registered once).
- Move sequence, with the request sampled at edge 0:
  - MOVE is high in cycle 1.
  - Each step takes 1+SETTLE_CYCLES cycles.
  - DLY_DONE is high in cycle 1+N*(1+SETTLE_CYCLES).
  - DLY_BUSY is high from cycle 1 through the DONE cycle inclusive.
- Load: LOAD high in cycle 1, DONE in cycle 2.
- N=0: DONE in cycle 1.
- Out-of-range abort on step j: DONE in cycle 1+j*(1+SETTLE_CYCLES).
- DIRECTION is valid from cycle 1, so it is stable at or before every MOVE edge.

## Structure
- Shared package ddr3_phy_pkg holds:
  - the sequencer state enum;
  - the TAP_W=8 constant;
  - the default SETTLE_CYCLES and INIT_TAP constants.
- One sub-module, ddr3_dly_step_fsm, holds the sequencer, tap tracker and OOR flag.
- The top level holds the TX/OE pipeline and instantiates the sub-module.

## Test plan
- Data path, TX_LATENCY=2: DFI_ADDR_P=4'hA, DFI_OE=1 at edge 0 -> TX_DATA_0=4'hA and OE_DATA_0=4'hF starting two edges later. Then DFI_OE=0 -> OE_DATA_0=0 with the same latency.
- Move: DLY_REQ with DIR=1, N=3, SETTLE=4 -> three MOVE pulses in cycles 1, 6, 11; DONE in cycle 16; DLY_TAP goes 1->4; DIRECTION=1 throughout.
- OOR abort: DIR=0, N=5, with OUT_OF_RANGE driven 1 during step 2 -> DONE in cycle 11; DLY_OOR=1; DLY_TAP=0 (decremented once from 1).
- Load priority: DLY_LOAD_REQ and DLY_REQ in the same cycle -> a single LOAD pulse, no MOVE, DLY_OOR cleared, DLY_TAP=INIT_TAP, DONE in cycle 2.
- Edge cases:
  - N=0 -> DONE in cycle 1 with no MOVE.
  - DLY_REQ during BUSY -> ignored.
  - ARST_N asserted mid-SETTLE -> all outputs reset and no DONE pulse.
